// File: rtl/rtc_font_pkg.sv
// Shared types and constants for the RTC time-text overlay.
//   glyph_t    : 4-bit glyph code (0..9 digits, 10 colon, 15 blank)
//   rom_addr_t : {bank select, glyph index} for the 8x16 font ROM
//   state_t    : serializer FSM states
package rtc_font_pkg;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_COLON = 4'd10;
  localparam glyph_t GLYPH_BLANK = 4'd15;

  // Font ROM bank layout: four glyphs per bank.
  localparam logic [3:0] BANK_BLANK = 4'd0;
  localparam logic [3:0] BANK_D0_3  = 4'd4;
  localparam logic [3:0] BANK_D4_7  = 4'd5;
  localparam logic [3:0] BANK_D8_9  = 4'd6;
  localparam logic [3:0] BANK_COLON = 4'd6;
  localparam logic [1:0] AD_COLON   = 2'd2;
  localparam logic [1:0] AD_BLANK   = 2'd0;

  localparam int WIN_W     = 64;
  localparam int WIN_H     = 16;
  localparam int NUM_SLOTS = 8;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] ad;
  } rom_addr_t;

  // Digit glyph for a BCD nibble; invalid nibbles and blink phase render blank.
  function automatic glyph_t digit_glyph(input logic [3:0] nib, input logic blank);
    return (blank || nib > 4'd9) ? GLYPH_BLANK : glyph_t'(nib);
  endfunction

endpackage

// File: rtl/rtc_glyph_map.sv
// Combinational glyph-code to font-ROM address map.
//   glyph : glyph code (digit, colon or blank)
//   addr  : {sel, ad} ROM bank and index within the bank
module rtc_glyph_map
  import rtc_font_pkg::*;
(
  input  glyph_t    glyph,
  output rom_addr_t addr
);

  always_comb begin
    addr.sel = BANK_BLANK;
    addr.ad  = AD_BLANK;
    case (glyph)
      4'd0, 4'd1, 4'd2, 4'd3: begin addr.sel = BANK_D0_3; addr.ad = glyph[1:0]; end
      4'd4, 4'd5, 4'd6, 4'd7: begin addr.sel = BANK_D4_7; addr.ad = glyph[1:0]; end
      4'd8, 4'd9:             begin addr.sel = BANK_D8_9; addr.ad = glyph[1:0]; end
      GLYPH_COLON:            begin addr.sel = BANK_COLON; addr.ad = AD_COLON; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_time_text_sequencer.sv
// Draws "HH:MM:SS" from an 8x16 font ROM inside a 64x16 window of the frame.
//   clk, reset                 : clock, async active-high reset
//   pixel_tick, video_on       : pixel enable, visible-area flag
//   pixel_x, pixel_y           : current raster position
//   hr/min/sec_bcd, edit_field : time to show (snapshotted at 0,0), field to blink
//   sel_caracter, AD, lsby     : font ROM address for the next glyph to load
//   rom_data                   : combinational ROM row, MSB leftmost
//   pixel_on                   : text pixel for the current position
module rtc_time_text_sequencer
  import rtc_font_pkg::*;
#(
  parameter int X0        = 200,
  parameter int Y0        = 232,
  parameter int BLINK_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pixel_tick,
  input  logic       video_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic [7:0] hr_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [1:0] edit_field,
  output logic [3:0] sel_caracter,
  output logic [1:0] AD,
  output logic [3:0] lsby,
  input  logic [7:0] rom_data,
  output logic       pixel_on
);

  localparam logic [9:0]  X_START = 10'(X0 - 1);
  localparam logic [9:0]  Y_TOP   = 10'(Y0);
  localparam logic [10:0] Y_LO    = 11'(Y0);
  localparam logic [10:0] Y_HI    = 11'(Y0 + WIN_H);

  state_t     state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] i_q, i_d;
  logic [2:0] k_q, k_d;

  logic [7:0] hr_q, min_q, sec_q;
  logic [1:0] edit_q;
  logic [5:0] fcnt_q, fcnt_inc;

  logic       snap, in_rows, line_start;
  logic [7:0] hr_e, min_e, sec_e;
  logic [1:0] edit_e;
  logic       blink_e;

  logic [2:0] ld_slot;
  logic [3:0] nib;
  logic [1:0] slot_field;
  logic       is_colon;
  glyph_t     glyph;
  rom_addr_t  addr;

  assign snap     = pixel_tick && !reset && (pixel_x == 10'd0) && (pixel_y == 10'd0);
  assign fcnt_inc = fcnt_q + 6'd1;
  assign in_rows  = ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

  // A snapshot on the same tick as a line start must already be visible to
  // the slot-0 fetch, so the fetch sees the incoming values on that tick.
  assign hr_e    = snap ? hr_bcd     : hr_q;
  assign min_e   = snap ? min_bcd    : min_q;
  assign sec_e   = snap ? sec_bcd    : sec_q;
  assign edit_e  = snap ? edit_field : edit_q;
  assign blink_e = snap ? fcnt_inc[BLINK_BIT] : fcnt_q[BLINK_BIT];

  assign line_start = pixel_tick && (state_q == S_IDLE) && (pixel_x == X_START) && in_rows;

  // Address always points at the slot loaded on the next qualifying tick.
  assign ld_slot = (state_q == S_IDLE) ? 3'd0 : k_q + 3'd1;

  always_comb begin
    nib        = 4'd0;
    slot_field = 2'd0;
    is_colon   = 1'b0;
    case (ld_slot)
      3'd0:    begin nib = hr_e[7:4];  slot_field = 2'd1; end
      3'd1:    begin nib = hr_e[3:0];  slot_field = 2'd1; end
      3'd3:    begin nib = min_e[7:4]; slot_field = 2'd2; end
      3'd4:    begin nib = min_e[3:0]; slot_field = 2'd2; end
      3'd6:    begin nib = sec_e[7:4]; slot_field = 2'd3; end
      3'd7:    begin nib = sec_e[3:0]; slot_field = 2'd3; end
      default: is_colon = 1'b1;
    endcase
  end

  // edit_e == 0 never matches a digit slot, so "no edit" needs no special case.
  assign glyph = is_colon ? GLYPH_COLON
                          : digit_glyph(nib, blink_e && (edit_e == slot_field));

  rtc_glyph_map u_map (
    .glyph (glyph),
    .addr  (addr)
  );

  assign sel_caracter = addr.sel;
  assign AD           = addr.ad;
  assign lsby         = (reset || !in_rows) ? 4'd0 : 4'(pixel_y - Y_TOP);

  assign pixel_on = video_on && (state_q == S_SHIFT) && sh_q[7];

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    i_d     = i_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (line_start) begin
          state_d = S_SHIFT;
          sh_d    = rom_data;
          i_d     = 3'd0;
          k_d     = 3'd0;
        end
      end
      S_SHIFT: begin
        if (pixel_tick) begin
          if (i_q != 3'd7) begin
            sh_d = {sh_q[6:0], 1'b0};
            i_d  = i_q + 3'd1;
          end else if (k_q != 3'(NUM_SLOTS - 1)) begin
            sh_d = rom_data;
            i_d  = 3'd0;
            k_d  = k_q + 3'd1;
          end else begin
            state_d = S_IDLE;
            sh_d    = 8'd0;
            i_d     = 3'd0;
            k_d     = 3'd0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= 8'd0;
      i_q     <= 3'd0;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      i_q     <= i_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr_q   <= 8'd0;
      min_q  <= 8'd0;
      sec_q  <= 8'd0;
      edit_q <= 2'd0;
      fcnt_q <= 6'd0;
    end else if (snap) begin
      hr_q   <= hr_bcd;
      min_q  <= min_bcd;
      sec_q  <= sec_bcd;
      edit_q <= edit_field;
      fcnt_q <= fcnt_inc;
    end
  end

endmodule

// File: tb/tb_rtc_time_text_sequencer.sv
module tb_rtc_time_text_sequencer;

  localparam int X0     = 8;
  localparam int Y0     = 4;
  localparam int BB     = 4;
  localparam int H_TOT  = 80;
  localparam int FRAMES = 70;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pixel_tick = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] pixel_x = '0;
  logic [9:0] pixel_y = '0;
  logic [7:0] hr_bcd = '0, min_bcd = '0, sec_bcd = '0;
  logic [1:0] edit_field = '0;
  logic [3:0] sel_caracter;
  logic [1:0] AD;
  logic [3:0] lsby;
  logic [7:0] rom_data;
  logic       pixel_on;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_hr = 0, m_min = 0, m_sec = 0, m_edit = 0, m_fcnt = 0;
  bit drawing = 0;
  logic exp_q[$];

  rtc_time_text_sequencer #(.X0(X0), .Y0(Y0), .BLINK_BIT(BB)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_tick   (pixel_tick),
    .video_on     (video_on),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .hr_bcd       (hr_bcd),
    .min_bcd      (min_bcd),
    .sec_bcd      (sec_bcd),
    .edit_field   (edit_field),
    .sel_caracter (sel_caracter),
    .AD           (AD),
    .lsby         (lsby),
    .rom_data     (rom_data),
    .pixel_on     (pixel_on)
  );

  always #5 clk = ~clk;

  // Synthetic font: bank 0 reads as zero, every other (bank, glyph, row) distinct.
  function automatic logic [7:0] font(input int b, input int a, input int r);
    if (b == 0) return 8'd0;
    return 8'((b * 53) ^ (a * 97 + r * 29) ^ 8'hA5);
  endfunction

  always_comb rom_data = font(int'(sel_caracter), int'(AD), int'(lsby));

  // Expected bitmap row for a slot, from the latched time/edit/frame count.
  function automatic logic [7:0] model_row(input int s, input int r);
    int byte_v, d;
    if (s % 3 == 2) return font(6, 2, r);
    byte_v = (s < 3) ? m_hr : (s < 6) ? m_min : m_sec;
    d = (s % 3 == 0) ? (byte_v >> 4) : (byte_v & 15);
    if (d > 9) return 8'd0;
    if (((m_fcnt >> BB) & 1) == 1 && m_edit == s / 3 + 1) return 8'd0;
    return font(4 + d / 4, d % 4, r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every ticked cycle presents one pixel to compare.
  always @(negedge clk) begin
    if (pixel_tick) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL pixel_sb: pixel at x=%0d y=%0d with empty scoreboard", pixel_x, pixel_y);
      end else begin
        logic e;
        e = exp_q.pop_front();
        n_checks++;
        if (pixel_on !== e) begin
          n_fail++;
          $display("FAIL pixel_on x=%0d y=%0d: got %0b expected %0b", pixel_x, pixel_y, pixel_on, e);
        end
      end
    end
  end

  task automatic step(input int x, input int y);
    logic e;
    int rel;
    #1;
    pixel_x    = 10'(x);
    pixel_y    = 10'(y);
    video_on   = ($urandom_range(9) != 0);
    pixel_tick = 1'b1;
    e = 1'b0;
    rel = x - X0;
    if (drawing && rel >= 0 && rel < 64) begin
      logic [7:0] row;
      row = model_row(rel / 8, y - Y0);
      e = row[7 - rel % 8] & video_on;
    end
    exp_q.push_back(e);
    @(posedge clk);
    if (x == 0 && y == 0) begin
      m_hr = hr_bcd; m_min = min_bcd; m_sec = sec_bcd; m_edit = edit_field;
      m_fcnt = (m_fcnt + 1) % 64;
    end
    if (drawing && x == X0 + 63) drawing = 0;
    else if (!drawing && x == X0 - 1 && y >= Y0 && y < Y0 + 16) drawing = 1;
    if ($urandom_range(3) == 0) begin
      #1 pixel_tick = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic line(input int y, input int reset_at);
    for (int x = 0; x < H_TOT; x++) begin
      if (x == reset_at) begin
        #1;
        pixel_tick = 1'b0;
        reset = 1'b1;
        #2 chk("reset_midline_pixel", {7'd0, pixel_on}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_hr = 0; m_min = 0; m_sec = 0; m_edit = 0; m_fcnt = 0;
        drawing = 0;
      end
      step(x, y);
    end
  endtask

  function automatic logic [3:0] rnd_nib();
    return ($urandom_range(7) == 0) ? 4'($urandom_range(15, 10)) : 4'($urandom_range(9));
  endfunction

  task automatic randomize_inputs();
    hr_bcd     = {rnd_nib(), rnd_nib()};
    min_bcd    = {rnd_nib(), rnd_nib()};
    sec_bcd    = {rnd_nib(), rnd_nib()};
    edit_field = 2'($urandom_range(3));
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_pixel_on", {7'd0, pixel_on}, 8'd0);
    chk("reset_sel", {4'd0, sel_caracter}, 8'd4);
    chk("reset_ad", {6'd0, AD}, 8'd0);
    chk("reset_lsby", {4'd0, lsby}, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);

    for (int f = 0; f < FRAMES; f++) begin
      if (f == 0) begin
        hr_bcd = 8'h12; min_bcd = 8'h34; sec_bcd = 8'h56; edit_field = 2'd0;
      end else if (f == 1) begin
        hr_bcd = 8'hA9; min_bcd = 8'h08; sec_bcd = 8'h59; edit_field = 2'd0;
      end else if (f >= 2 && f < 40) begin
        randomize_inputs();
        edit_field = 2'd2;
      end else begin
        randomize_inputs();
      end
      line(0, -1);
      line(Y0 - 1, -1);
      line(Y0 + 5, (f == 20) ? X0 + 20 : -1);
      // Mid-frame input change: must not show until the next snapshot.
      randomize_inputs();
      line(Y0 + int'($urandom_range(1, 14)), -1);
      line(Y0 + 15, -1);
      line(Y0 + 16, -1);
      if (f == 20) chk("post_reset_fcnt_model", 8'(m_fcnt), 8'd0);
    end

    #2;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_time_text_sequencer.md
# rtc_time_text_sequencer

Sequences the 8×16 font ROM to draw the time string "HH:MM:SS" inside a fixed 64×16-pixel window of the VGA frame. It sits between the VGA sync generator and the colour mux. It snapshots the BCD time once per frame, blinks the field being edited, and issues one ROM row fetch per glyph cell. The fetched row is serialized to a 1-bit pixel stream aligned to `pixel_x`.

## Interface
- `X0`, default 200: window left column; legal range 1..575.
- `Y0`, default 232: window top row.
- `BLINK_BIT`, default 4: frame-counter bit that gates blinking (about 0.5 s period at 60 Hz).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous reset, active-high.
- `pixel_tick` in 1: one-cycle pixel enable.
- `video_on` in 1: visible-area flag.
- `pixel_x` in 10: current column, advances on `pixel_tick`.
- `pixel_y` in 10: current row.
- `hr_bcd`, `min_bcd`, `sec_bcd` in 8 each: tens digit in [7:4], ones digit in [3:0].
- `edit_field` in 2: 0 = none, 1 = hours, 2 = minutes, 3 = seconds.
- `sel_caracter` out 4: ROM bank select.
- `AD` out 2: glyph index within the bank.
- `lsby` out 4: glyph row.
- `rom_data` in 8: ROM row bitmap, combinational from the address; MSB is the leftmost pixel.
- `pixel_on` out 1: text pixel for the current `pixel_x`/`pixel_y`.

## Operation
- **Glyph map** (glyph code to `sel_caracter`/`AD`):
  - Digit d in 0..3 maps to bank 4, `AD` = d.
  - Digit d in 4..7 maps to bank 5, `AD` = d−4.
  - Digit d in 8..9 maps to bank 6, `AD` = d−8.
  - Colon maps to bank 6, `AD` = 2.
  - Blank maps to bank 0, `AD` = 0; the ROM returns 0 for bank 0.
- **Glyph slots** k = 0..7: hr tens, hr ones, ':', min tens, min ones, ':', sec tens, sec ones.
- **Snapshot**: on a `pixel_tick` with `pixel_x`==0 and `pixel_y`==0, latch all three BCD inputs and `edit_field`, and increment the 6-bit frame counter `fcnt` (wraps).
- **Blank rules** for a digit glyph:
  - BCD nibble > 9 gives blank.
  - Blank also when `fcnt[BLINK_BIT]`==1 and the slot belongs to the latched edit field.
  - Colons never blink.
- **State machine** with states IDLE and SHIFT. Registers: shift register `sh[7:0]`, bit counter `i[2:0]`, slot counter `k[2:0]`.
  - IDLE to SHIFT on a `pixel_tick` with `pixel_x`==X0−1 and Y0 ≤ `pixel_y` < Y0+16. On that edge: load `sh`←`rom_data` for slot 0, set `i`=0 and `k`=0.
  - In SHIFT, each `pixel_tick` with `i`<7: `sh`←`sh`<<1 and `i`++.
  - In SHIFT, each `pixel_tick` with `i`==7 and `k`<7: `k`++, load `sh` with the row for slot k+1, set `i`=0.
  - In SHIFT, each `pixel_tick` with `i`==7 and `k`==7: return to IDLE and clear `sh` to 0.
- **ROM address**: always driven for the slot about to be loaded (slot 0 in IDLE, slot k+1 in SHIFT). `lsby` = (`pixel_y`−Y0)[3:0]; it is don't-care outside the window rows.
- **pixel_on** = `video_on` & (state==SHIFT) & `sh[7]`.

## Timing
- Reset values: state IDLE, `sh`=0, `i`=0, `k`=0, `fcnt`=0, snapshot registers 0. Outputs: `pixel_on`=0, `sel_caracter`=4, `AD`=0, `lsby`=0.
- Fetch latency: the ROM is combinational, so fetch and load happen in the same cycle. Glyph k's row is loaded on the tick at `pixel_x`=X0+8k−1. Bit 7−j appears while `pixel_x`=X0+8k+j.
- Between ticks, all state holds.
- `video_on` low masks `pixel_on` only; the FSM keeps running.
- Reset asserted mid-line: `pixel_on` drops to 0 immediately. Drawing resumes at the next qualifying X0−1 tick; a partial line is never resumed.
- Snapshot and line-start on the same tick (only possible when Y0=0): the snapshot is applied first. Row 0 of that frame uses the new values.
- `fcnt` wrap 63→0 behaves as a normal blink edge.

## Structure
- Package `rtc_font_pkg` holds:
  - Glyph code type: 4 bits, 0–9 digits, 10 colon, 15 blank.
  - Bank and AD constants.
  - Window width 64 and height 16.
  - State enum.
- Sub-module `rtc_glyph_map`: combinational, glyph code in, {`sel_caracter`, `AD`} out.
- The top level handles the FSM, snapshot, blink counter and serializer.

## Test plan
- **Time 12:34:56, no edit, real font ROM attached.** At `pixel_y`=Y0+5, `pixel_on` across X0..X0+7 equals the '1' row (00010000). Cells X0+16..23 show the colon row 00110000.
- **Bad hour BCD `hr_bcd`=8'hA9.** The tens glyph is blank (all 0 over X0..X0+7 on every row). The ones glyph '9' draws normally.
- **`edit_field`=2, run 64 frames.** Minute cells are blank exactly when `fcnt[4]`=1. Hours, seconds and colons are unaffected.
- **Change `sec_bcd` mid-frame.** The rendered digits change only on the frame after the 0,0 snapshot tick.
- **Assert `reset` at `pixel_x`=X0+20.** `pixel_on`=0 for the rest of the line. The next line renders fully from X0.
- **Row bounds.** `pixel_y`=Y0−1 and `pixel_y`=Y0+16 give `pixel_on`=0 on every column. `pixel_y`=Y0+15 renders row 15 of each glyph.
